ring_step_sequencer: RTL and testbench

Command-driven sequencer for the 3-bit ring state used by the forward/reverse rotate stage. It accepts step commands (direction, step count, step interval) over a valid/ready handshake, owns the ring state register `Q`, and emits the per-step `F`/`R` rotate strobes for downstream consumers. The register only moves on a scheduled step: a forward step rotates `Q` one way, a reverse step rotates it the other way, and otherwise `Q` holds.

---
 rtl/ring_step_sequencer.sv | 85 ++++++++
 tb/tb_ring_step_sequencer.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/ring_step_sequencer.sv
// Command-driven sequencer for the 3-bit ring state: accepts (dir, steps, interval) commands,
// rotates Q once per scheduled step and emits registered F/R strobes plus a done pulse.
module ring_step_sequencer #(
  parameter int unsigned CNT_W = 8,
  parameter int unsigned DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_dir,
  input  logic [CNT_W-1:0] cmd_steps,
  input  logic [DIV_W-1:0] cmd_div,
  input  logic             abort,
  output logic [0:2]       Q,
  output logic             F,
  output logic             R,
  output logic             busy,
  output logic             done
);

  typedef enum logic {StIdle, StRun} state_e;

  state_e           state_q;
  logic             dir_q;
  logic [CNT_W-1:0] remaining_q;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] timer_q;

  assign cmd_ready = (state_q == StIdle) && !rst;
  assign busy      = (state_q == StRun);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      Q           <= 3'b100;
      F           <= 1'b0;
      R           <= 1'b0;
      done        <= 1'b0;
      dir_q       <= 1'b0;
      remaining_q <= '0;
      div_q       <= '0;
      timer_q     <= '0;
    end else begin
      F    <= 1'b0;
      R    <= 1'b0;
      done <= 1'b0;
      case (state_q)
        StIdle: begin
          if (cmd_valid) begin
            if (cmd_steps == '0) begin
              done <= 1'b1;
            end else begin
              dir_q       <= cmd_dir;
              remaining_q <= cmd_steps;
              div_q       <= cmd_div;
              timer_q     <= cmd_div;
              state_q     <= StRun;
            end
          end
        end
        StRun: begin
          if (abort) begin
            state_q <= StIdle;
          end else if (timer_q == '0) begin
            // Forward walks 100 -> 001 -> 010, reverse walks 100 -> 010 -> 001.
            if (dir_q) Q <= {Q[1], Q[2], Q[0]};
            else       Q <= {Q[2], Q[0], Q[1]};
            F           <= dir_q;
            R           <= !dir_q;
            timer_q     <= div_q;
            remaining_q <= remaining_q - CNT_W'(1);
            if (remaining_q == CNT_W'(1)) begin
              state_q <= StIdle;
              done    <= 1'b1;
            end
          end else begin
            timer_q <= timer_q - DIV_W'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ring_step_sequencer.sv
// Bench for ring_step_sequencer: directed and random commands checked against a step-schedule
// model that tracks the ring position as an index into the forward visiting order.
module tb_ring_step_sequencer;

  localparam int unsigned CNT_W = 8;
  localparam int unsigned DIV_W = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic             cmd_dir = 1'b0;
  logic [CNT_W-1:0] cmd_steps = '0;
  logic [DIV_W-1:0] cmd_div = '0;
  logic             abort = 1'b0;
  logic [0:2]       Q;
  logic             F;
  logic             R;
  logic             busy;
  logic             done;

  always #5 clk = ~clk;

  ring_step_sequencer #(.CNT_W(CNT_W), .DIV_W(DIV_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_dir  (cmd_dir),
    .cmd_steps(cmd_steps),
    .cmd_div  (cmd_div),
    .abort    (abort),
    .Q        (Q),
    .F        (F),
    .R        (R),
    .busy     (busy),
    .done     (done)
  );

  int passed = 0;
  int total  = 0;
  int pos    = 0;  // index into ring[]: forward is +1, reverse is -1 (mod 3)
  logic [2:0] ring [3];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_outputs(input string tag, input int e_busy, input int e_done,
                               input int e_f, input int e_r);
    check({tag, ".q"},     32'(Q),         32'(ring[pos]));
    check({tag, ".busy"},  32'(busy),      32'(e_busy));
    check({tag, ".done"},  32'(done),      32'(e_done));
    check({tag, ".f"},     32'(F),         32'(e_f));
    check({tag, ".r"},     32'(R),         32'(e_r));
    check({tag, ".ready"}, 32'(cmd_ready), 32'(e_busy == 0));
  endtask

  // Entered in a cycle where the sequencer is ready; returns in the done/abort/idle cycle.
  // abort_k > 0 raises abort for the cycle ending at edge E0+abort_k.
  task automatic run_cmd(input string tag, input bit d, input int steps, input int dv,
                         input int abort_k);
    int  dur;
    bit  stepnow;
    dur = steps * (dv + 1);
    cmd_valid = 1'b1;
    cmd_dir   = d;
    cmd_steps = CNT_W'(steps);
    cmd_div   = DIV_W'(dv);
    check({tag, ".accept_ready"}, 32'(cmd_ready), 32'd1);
    tick();
    cmd_valid = 1'b0;
    // Fields must only matter at acceptance.
    cmd_dir   = 1'($urandom_range(1, 0));
    cmd_steps = CNT_W'($urandom);
    cmd_div   = DIV_W'($urandom);
    if (steps == 0) begin
      check_outputs({tag, ".zero"}, 0, 1, 0, 0);
      return;
    end
    check_outputs({tag, ".k0"}, 1, 0, 0, 0);
    for (int k = 1; k <= dur; k++) begin
      abort = (k == abort_k);
      tick();
      if (k == abort_k) begin
        abort = 1'b0;
        check_outputs({tag, ".abort"}, 0, 0, 0, 0);
        return;
      end
      stepnow = (k % (dv + 1)) == 0;
      if (stepnow) pos = d ? (pos + 1) % 3 : (pos + 2) % 3;
      check_outputs($sformatf("%s.k%0d", tag, k), (k < dur) ? 1 : 0, (k == dur) ? 1 : 0,
                    (stepnow && d) ? 1 : 0, (stepnow && !d) ? 1 : 0);
    end
  endtask

  initial begin
    int  n_steps;
    int  n_div;
    int  ab;
    int  gap;
    ring = '{3'b100, 3'b001, 3'b010};

    // Reset held for two cycles
    repeat (2) begin
      tick();
      check("rst.q",     32'(Q),         32'(3'b100));
      check("rst.f",     32'(F),         32'd0);
      check("rst.r",     32'(R),         32'd0);
      check("rst.done",  32'(done),      32'd0);
      check("rst.busy",  32'(busy),      32'd0);
      check("rst.ready", 32'(cmd_ready), 32'd0);
    end
    rst = 1'b0;
    #1;
    check("rel.ready", 32'(cmd_ready), 32'd1);
    pos = 0;

    run_cmd("fwd3", 1'b1, 3, 0, -1);
    check("fwd3.q_end", 32'(Q), 32'(3'b100));
    run_cmd("rev2", 1'b0, 2, 2, -1);
    check("rev2.q_end", 32'(Q), 32'(3'b001));

    run_cmd("zero", 1'b1, 0, 5, -1);
    tick();
    check_outputs("zero.after", 0, 0, 0, 0);

    // Abort in the cycle where the second step (edge E0+8) is due
    run_cmd("abort", 1'b1, 5, 3, 8);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_outputs("idle_abort", 0, 0, 0, 0);

    // Back-to-back: second command accepted in the first one's done cycle
    run_cmd("b2b_rev", 1'b0, 1, 0, -1);
    run_cmd("b2b_fwd", 1'b1, 1, 0, -1);

    run_cmd("max", 1'b1, (1 << CNT_W) - 1, 0, -1);
    tick();
    check_outputs("max.after", 0, 0, 0, 0);

    for (int n = 0; n < 25; n++) begin
      n_steps = $urandom_range(12, 0);
      n_div   = $urandom_range(5, 0);
      ab      = -1;
      if (n_steps != 0 && $urandom_range(3, 0) == 0)
        ab = $urandom_range(n_steps * (n_div + 1), 1);
      run_cmd($sformatf("rnd%0d", n), 1'($urandom_range(1, 0)), n_steps, n_div, ab);
      gap = $urandom_range(2, 0);
      repeat (gap) begin
        tick();
        check_outputs($sformatf("rnd%0d.gap", n), 0, 0, 0, 0);
      end
    end

    // Reset in the middle of a running command
    cmd_valid = 1'b1;
    cmd_dir   = 1'b1;
    cmd_steps = CNT_W'(10);
    cmd_div   = DIV_W'(1);
    tick();
    cmd_valid = 1'b0;
    repeat (3) tick();
    check("mid.busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    check("mid.q",     32'(Q),         32'(3'b100));
    check("mid.busy",  32'(busy),      32'd0);
    check("mid.f",     32'(F),         32'd0);
    check("mid.r",     32'(R),         32'd0);
    check("mid.done",  32'(done),      32'd0);
    check("mid.ready", 32'(cmd_ready), 32'd0);
    rst = 1'b0;
    pos = 0;
    #1;
    run_cmd("post_rst", 1'b0, 2, 1, -1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
